reg_bank_shadow: RTL and testbench

//   Parametrised bank of NCH independent WIDTH-bit working registers, each with enable,
//   per-channel op select (hold/load/shift/increment) and synchronous clear.
//   A shadow register per channel captures all working registers atomically on commit,

---
 rtl/reg_bank_shadow.sv | 79 +++++++
 tb/tb_reg_bank_shadow.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_shadow.sv
// rtl/reg_bank_shadow.sv - bank of NCH working registers with atomic shadow snapshot
module reg_bank_shadow #(
  parameter int              WIDTH     = 8,
  parameter int              NCH       = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       en,
  input  logic [2*NCH-1:0]     op,
  input  logic [NCH*WIDTH-1:0] d,
  input  logic [NCH-1:0]       sin,
  input  logic                 clr,
  input  logic                 commit,
  output logic [NCH*WIDTH-1:0] q_work,
  output logic [NCH*WIDTH-1:0] q_shadow,
  output logic [NCH-1:0]       sout,
  output logic [NCH-1:0]       wrap,
  output logic                 commit_ack
);

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_SHIFT = 2'b10;
  localparam logic [1:0] OP_INC   = 2'b11;

  logic [NCH*WIDTH-1:0] work_nxt;
  logic [NCH-1:0]       sout_nxt;
  logic [NCH-1:0]       wrap_nxt;
  logic [WIDTH-1:0]     cur;

  // clr outranks any enabled op; wrap is a pulse so it defaults low every cycle
  always_comb begin
    work_nxt = q_work;
    sout_nxt = sout;
    wrap_nxt = '0;
    cur      = '0;
    for (int i = 0; i < NCH; i++) begin
      cur = q_work[WIDTH*i +: WIDTH];
      if (clr) begin
        work_nxt[WIDTH*i +: WIDTH] = RESET_VAL;
      end else if (en[i]) begin
        case (op[2*i +: 2])
          OP_LOAD: work_nxt[WIDTH*i +: WIDTH] = d[WIDTH*i +: WIDTH];
          OP_SHIFT: begin
            work_nxt[WIDTH*i +: WIDTH] = {cur[WIDTH-2:0], sin[i]};
            sout_nxt[i]                = cur[WIDTH-1];
          end
          OP_INC: begin
            work_nxt[WIDTH*i +: WIDTH] = cur + 1'b1;
            wrap_nxt[i]                = &cur;
          end
          OP_HOLD: ;
          default: ;
        endcase
      end
    end
  end

  // shadow takes the pre-edge working values, independent of this cycle's ops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_work     <= {NCH{RESET_VAL}};
      q_shadow   <= {NCH{RESET_VAL}};
      sout       <= '0;
      wrap       <= '0;
      commit_ack <= 1'b0;
    end else begin
      q_work     <= work_nxt;
      sout       <= sout_nxt;
      wrap       <= wrap_nxt;
      commit_ack <= commit;
      if (commit) begin
        q_shadow <= q_work;
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_shadow.sv
// tb/tb_reg_bank_shadow.sv - directed table, async reset and randomized model checks
module tb_reg_bank_shadow;

  localparam int WIDTH = 8;
  localparam int NCH   = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  en;
  logic [5:0]  op;
  logic [23:0] d;
  logic [2:0]  sin;
  logic        clr;
  logic        commit;
  logic [23:0] q_work;
  logic [23:0] q_shadow;
  logic [2:0]  sout;
  logic [2:0]  wrap;
  logic        commit_ack;

  int checks   = 0;
  int failures = 0;

  int mw[NCH];
  int ms[NCH];
  int msout[NCH];
  int mwrap[NCH];
  int mack;

  typedef struct {
    logic [2:0]  en;
    logic [5:0]  op;
    logic [23:0] d;
    logic [2:0]  sin;
    logic        clr;
    logic        commit;
    logic [23:0] work;
    logic [23:0] shadow;
    logic [2:0]  sout;
    logic [2:0]  wrap;
    logic        ack;
  } vec_t;

  vec_t vecs[13];

  reg_bank_shadow #(.WIDTH(WIDTH), .NCH(NCH), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .en(en), .op(op), .d(d), .sin(sin), .clr(clr),
    .commit(commit), .q_work(q_work), .q_shadow(q_shadow), .sout(sout),
    .wrap(wrap), .commit_ack(commit_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      mw[i] = 0; ms[i] = 0; msout[i] = 0; mwrap[i] = 0;
    end
    mack = 0;
  endtask

  // Reference: plain arithmetic on per-channel integers
  task automatic model_step();
    int old[NCH];
    int o;
    for (int i = 0; i < NCH; i++) old[i] = mw[i];
    for (int i = 0; i < NCH; i++) begin
      mwrap[i] = 0;
      o = int'(op[2*i +: 2]);
      if (clr) mw[i] = 0;
      else if (en[i]) begin
        if (o == 1) mw[i] = int'(d[8*i +: 8]);
        else if (o == 2) begin
          msout[i] = old[i] / 128;
          mw[i]    = (old[i] * 2 + int'(sin[i])) % 256;
        end else if (o == 3) begin
          mwrap[i] = (old[i] == 255) ? 1 : 0;
          mw[i]    = (old[i] + 1) % 256;
        end
      end
      if (commit) ms[i] = old[i];
    end
    mack = commit ? 1 : 0;
  endtask

  task automatic compare_model(input string tag);
    logic [23:0] ew, es;
    logic [2:0]  eo, ep;
    ew = '0; es = '0; eo = '0; ep = '0;
    for (int i = 0; i < NCH; i++) begin
      ew[8*i +: 8] = 8'(mw[i]);
      es[8*i +: 8] = 8'(ms[i]);
      eo[i]        = 1'(msout[i]);
      ep[i]        = 1'(mwrap[i]);
    end
    chk({tag, "_work"}, 32'(q_work), 32'(ew));
    chk({tag, "_shadow"}, 32'(q_shadow), 32'(es));
    chk({tag, "_sout"}, 32'(sout), 32'(eo));
    chk({tag, "_wrap"}, 32'(wrap), 32'(ep));
    chk({tag, "_ack"}, 32'(commit_ack), 32'(mack));
  endtask

  task automatic drive_idle();
    en = '0; op = '0; d = '0; sin = '0; clr = 1'b0; commit = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{3'b001, 6'b000001, 24'h0000A5, 3'b000, 1'b0, 1'b0, 24'h0000A5, 24'h000000, 3'b000, 3'b000, 1'b0};
    vecs[1]  = '{3'b110, 6'b010100, 24'hFF8100, 3'b000, 1'b0, 1'b0, 24'hFF81A5, 24'h000000, 3'b000, 3'b000, 1'b0};
    vecs[2]  = '{3'b010, 6'b001000, 24'h000000, 3'b000, 1'b0, 1'b0, 24'hFF02A5, 24'h000000, 3'b010, 3'b000, 1'b0};
    vecs[3]  = '{3'b010, 6'b001000, 24'h000000, 3'b000, 1'b0, 1'b0, 24'hFF04A5, 24'h000000, 3'b000, 3'b000, 1'b0};
    vecs[4]  = '{3'b100, 6'b110000, 24'h000000, 3'b000, 1'b0, 1'b0, 24'h0004A5, 24'h000000, 3'b000, 3'b100, 1'b0};
    vecs[5]  = '{3'b100, 6'b110000, 24'h000000, 3'b000, 1'b0, 1'b0, 24'h0104A5, 24'h000000, 3'b000, 3'b000, 1'b0};
    vecs[6]  = '{3'b001, 6'b000001, 24'h000010, 3'b000, 1'b0, 1'b0, 24'h010410, 24'h000000, 3'b000, 3'b000, 1'b0};
    vecs[7]  = '{3'b001, 6'b000011, 24'h000000, 3'b000, 1'b0, 1'b1, 24'h010411, 24'h010410, 3'b000, 3'b000, 1'b1};
    vecs[8]  = '{3'b111, 6'b010101, 24'h123456, 3'b000, 1'b1, 1'b0, 24'h000000, 24'h010410, 3'b000, 3'b000, 1'b0};
    vecs[9]  = '{3'b111, 6'b010101, 24'hC33C5A, 3'b000, 1'b0, 1'b1, 24'hC33C5A, 24'h000000, 3'b000, 3'b000, 1'b1};
    vecs[10] = '{3'b000, 6'b000000, 24'h000000, 3'b000, 1'b0, 1'b1, 24'hC33C5A, 24'hC33C5A, 3'b000, 3'b000, 1'b1};
    vecs[11] = '{3'b111, 6'b101010, 24'h000000, 3'b111, 1'b0, 1'b0, 24'h8779B5, 24'hC33C5A, 3'b100, 3'b000, 1'b0};
    vecs[12] = '{3'b000, 6'b111111, 24'hFFFFFF, 3'b000, 1'b0, 1'b0, 24'h8779B5, 24'hC33C5A, 3'b100, 3'b000, 1'b0};

    reset = 1'b0;
    drive_idle();
    step();
    step();
    chk("rst_work", 32'(q_work), 32'h0);
    chk("rst_shadow", 32'(q_shadow), 32'h0);
    chk("rst_flags", 32'({sout, wrap, commit_ack}), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < 13; k++) begin
      en = vecs[k].en; op = vecs[k].op; d = vecs[k].d; sin = vecs[k].sin;
      clr = vecs[k].clr; commit = vecs[k].commit;
      step();
      chk($sformatf("v%0d_work", k), 32'(q_work), 32'(vecs[k].work));
      chk($sformatf("v%0d_shadow", k), 32'(q_shadow), 32'(vecs[k].shadow));
      chk($sformatf("v%0d_sout", k), 32'(sout), 32'(vecs[k].sout));
      chk($sformatf("v%0d_wrap", k), 32'(wrap), 32'(vecs[k].wrap));
      chk($sformatf("v%0d_ack", k), 32'(commit_ack), 32'(vecs[k].ack));
    end

    // Async reset mid-increment with commit pending: outputs clear before the next edge
    en = 3'b111; op = 6'b111111; commit = 1'b1;
    step();
    chk("inc_before_rst", 32'(q_work), 32'h887AB6);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_work", 32'(q_work), 32'h0);
    chk("async_rst_shadow", 32'(q_shadow), 32'h0);
    chk("async_rst_flags", 32'({sout, wrap, commit_ack}), 32'h0);
    step();
    chk("held_rst_work", 32'(q_work), 32'h0);
    drive_idle();
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    for (int n = 0; n < 400; n++) begin
      en     = 3'($urandom);
      op     = 6'($urandom);
      sin    = 3'($urandom);
      clr    = ($urandom_range(0, 15) == 0);
      commit = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NCH; i++) begin
        case ($urandom_range(0, 3))
          0: d[8*i +: 8] = 8'hFF;
          1: d[8*i +: 8] = 8'hFE;
          default: d[8*i +: 8] = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 99) == 0) begin
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        compare_model("rnd_rst");
        @(negedge clk);
        reset = 1'b1;
      end else begin
        model_step();
        step();
        compare_model("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
